// File: rtl/clock_enable_controller_pkg.sv
// Shared definitions for the clock-enable controller: mode encodings and the
// default breakpoint countdown length.
package clock_enable_controller_pkg;

   typedef enum logic [1:0] {
      CLK_MODE_RUN       = 2'd0,
      CLK_MODE_MANUAL    = 2'd1,
      CLK_MODE_HALT      = 2'd2,
      CLK_MODE_COUNTDOWN = 2'd3
   } clk_mode_e;

   localparam int unsigned DEFAULT_COUNTDOWN_CYCLES = 50_000_000;

endpackage

// File: rtl/clock_enable_controller_enable_divider.sv
// One enable channel: up-counter against a divisor latched at each wrap, with
// a registered one-cycle pulse. The FSM supplies run/clear/step controls.
module enable_divider #(
   parameter int DIV_WIDTH = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 active_i,
   input  logic                 run_i,
   input  logic                 clear_i,
   input  logic                 step_i,
   input  logic [DIV_WIDTH-1:0] divisor_i,
   output logic                 enable_o
);

   logic [DIV_WIDTH-1:0] count_q, count_d;
   logic [DIV_WIDTH-1:0] latch_q, latch_d;
   logic                 enable_q, enable_d;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      count_d  = count_q;
      latch_d  = latch_q;
      enable_d = 1'b0;
      if (!active_i) begin
         count_d = '0;
         latch_d = divisor_i;
      end else if (clear_i) begin
         count_d = '0;
      end else if (run_i) begin
         // A new divisor is only picked up at the wrap, so a period never changes length midway.
         if (count_q == latch_q) begin
            count_d  = '0;
            latch_d  = divisor_i;
            enable_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end else begin
         enable_d = step_i;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q  <= '0;
         latch_q  <= '0;
         enable_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         latch_q  <= latch_d;
         enable_q <= enable_d;
      end
   end

   assign enable_o = enable_q;

endmodule

// File: rtl/clock_enable_controller.sv
// Mode FSM (run / manual / halt / countdown) gating CHANNELS enable dividers
// that all run from the single free-running clock.
module clock_enable_controller
   import clock_enable_controller_pkg::*;
#(
   parameter int          CHANNELS         = 2,
   parameter int          DIV_WIDTH        = 5,
   parameter int          COUNTDOWN_WIDTH  = 26,
   parameter int unsigned COUNTDOWN_CYCLES = DEFAULT_COUNTDOWN_CYCLES
) (
   input  logic                          clock_100mhz,
   input  logic                          reset,
   input  logic [CHANNELS*DIV_WIDTH-1:0] channel_divisor,
   input  logic [CHANNELS-1:0]           channel_active,
   input  logic                          mode_toggle,
   input  logic                          manual_step,
   input  logic                          hard_breakpoint,
   input  logic                          soft_breakpoint,
   input  logic                          countdown_enable,
   output logic [CHANNELS-1:0]           clock_enable,
   output logic [1:0]                    mode,
   output logic                          countdown_active
);

   localparam logic [COUNTDOWN_WIDTH-1:0] CD_LOAD = COUNTDOWN_WIDTH'(COUNTDOWN_CYCLES - 1);

   clk_mode_e                  state_q, state_d;
   logic [COUNTDOWN_WIDTH-1:0] count_q, count_d;
   logic                       soft_q;
   logic                       soft_edge;
   logic                       step;
   logic                       run;
   logic                       clear;

   assign soft_edge = soft_breakpoint & ~soft_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      step    = 1'b0;
      unique case (state_q)
         CLK_MODE_RUN: begin
            if (hard_breakpoint) begin
               state_d = CLK_MODE_HALT;
            end else if (soft_edge) begin
               if (countdown_enable) begin
                  state_d = CLK_MODE_COUNTDOWN;
                  count_d = CD_LOAD;
               end else begin
                  state_d = CLK_MODE_HALT;
               end
            end else if (mode_toggle) begin
               state_d = CLK_MODE_MANUAL;
            end
         end
         CLK_MODE_MANUAL: begin
            if (hard_breakpoint)  state_d = CLK_MODE_HALT;
            else if (mode_toggle) state_d = CLK_MODE_RUN;
            else                  step    = manual_step;
         end
         CLK_MODE_HALT: begin
            if (mode_toggle && !hard_breakpoint) state_d = CLK_MODE_RUN;
            else                                 step    = manual_step;
         end
         CLK_MODE_COUNTDOWN: begin
            if (hard_breakpoint || !countdown_enable) state_d = CLK_MODE_HALT;
            else if (mode_toggle)                     state_d = CLK_MODE_MANUAL;
            else if (count_q == '0)                   state_d = CLK_MODE_RUN;
            else                                      count_d = count_q - 1'b1;
         end
         default: state_d = CLK_MODE_RUN;
      endcase
   end

   // Dividers count only across cycles that both start and end in RUN, so no
   // divider pulse can land in a non-RUN cycle; entering RUN restarts them.
   assign run   = (state_q == CLK_MODE_RUN) && (state_d == CLK_MODE_RUN);
   assign clear = (state_q != CLK_MODE_RUN) && (state_d == CLK_MODE_RUN);

   always_ff @(posedge clock_100mhz or posedge reset) begin
      if (reset) begin
         state_q <= CLK_MODE_RUN;
         count_q <= '0;
         soft_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         soft_q  <= soft_breakpoint;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
      enable_divider #(
         .DIV_WIDTH(DIV_WIDTH)
      ) u_divider (
         .clk_i    (clock_100mhz),
         .rst_i    (reset),
         .active_i (channel_active[k]),
         .run_i    (run),
         .clear_i  (clear),
         .step_i   (step),
         .divisor_i(channel_divisor[k*DIV_WIDTH +: DIV_WIDTH]),
         .enable_o (clock_enable[k])
      );
   end

   assign mode             = state_q;
   assign countdown_active = (state_q == CLK_MODE_COUNTDOWN);

endmodule

// File: tb/tb_clock_enable_controller.sv
// Bench for clock_enable_controller: a cycle model derived from the mode and
// divider rules, compared every cycle, plus directed literal expectations.
module tb_clock_enable_controller;

   localparam int CH  = 2;
   localparam int DW  = 5;
   localparam int CDN = 10;

   logic              clock_100mhz = 1'b0;
   logic              reset;
   logic [CH*DW-1:0]  channel_divisor;
   logic [CH-1:0]     channel_active;
   logic              mode_toggle, manual_step, hard_breakpoint;
   logic              soft_breakpoint, countdown_enable;
   logic [CH-1:0]     clock_enable;
   logic [1:0]        mode;
   logic              countdown_active;

   int n_checks = 0;
   int n_errors = 0;

   clock_enable_controller #(
      .CHANNELS(CH), .DIV_WIDTH(DW), .COUNTDOWN_WIDTH(26), .COUNTDOWN_CYCLES(CDN)
   ) dut (
      .clock_100mhz    (clock_100mhz),
      .reset           (reset),
      .channel_divisor (channel_divisor),
      .channel_active  (channel_active),
      .mode_toggle     (mode_toggle),
      .manual_step     (manual_step),
      .hard_breakpoint (hard_breakpoint),
      .soft_breakpoint (soft_breakpoint),
      .countdown_enable(countdown_enable),
      .clock_enable    (clock_enable),
      .mode            (mode),
      .countdown_active(countdown_active)
   );

   always #5 clock_100mhz = ~clock_100mhz;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode as an integer, per channel the cycles left before its wrap
   // and the period in force, countdown as cycles spent so far.
   int          m_mode = 0;
   int          m_spent = 0;
   bit          m_soft_prev = 1'b0;
   int          m_left[CH];
   int          m_period[CH];
   logic [CH-1:0] m_en = '0;

   task automatic model_step();
      bit soft_edge;
      bit step;
      int nxt;
      int div;
      if (reset) begin
         m_mode = 0; m_spent = 0; m_soft_prev = 1'b0; m_en = '0;
         for (int k = 0; k < CH; k++) begin m_left[k] = 0; m_period[k] = 0; end
      end else begin
         soft_edge   = soft_breakpoint && !m_soft_prev;
         m_soft_prev = soft_breakpoint;
         nxt  = m_mode;
         step = 1'b0;
         case (m_mode)
            0: if (hard_breakpoint) nxt = 2;
               else if (soft_edge) begin
                  if (countdown_enable) begin nxt = 3; m_spent = 0; end
                  else nxt = 2;
               end else if (mode_toggle) nxt = 1;
            1: if (hard_breakpoint) nxt = 2;
               else if (mode_toggle) nxt = 0;
               else step = manual_step;
            2: if (mode_toggle && !hard_breakpoint) nxt = 0;
               else step = manual_step;
            default: if (hard_breakpoint || !countdown_enable) nxt = 2;
               else if (mode_toggle) nxt = 1;
               else begin
                  m_spent++;
                  if (m_spent == CDN) nxt = 0;
               end
         endcase
         for (int k = 0; k < CH; k++) begin
            div = int'(channel_divisor[k*DW +: DW]);
            m_en[k] = 1'b0;
            if (!channel_active[k]) begin
               m_period[k] = div; m_left[k] = div;
            end else if (nxt == 0 && m_mode != 0) begin
               m_left[k] = m_period[k];
            end else if (nxt == 0) begin
               if (m_left[k] == 0) begin
                  m_en[k] = 1'b1; m_period[k] = div; m_left[k] = div;
               end else begin
                  m_left[k]--;
               end
            end else begin
               m_en[k] = step;
            end
         end
         m_mode = nxt;
      end
   endtask

   initial begin
      forever begin
         @(posedge clock_100mhz or posedge reset);
         model_step();
      end
   end

   always @(negedge clock_100mhz) begin
      check("clock_enable", clock_enable, m_en);
      check("mode", mode, m_mode[1:0]);
      check("countdown_active", countdown_active, m_mode == 3);
   end

   task automatic pulse_toggle();
      mode_toggle = 1'b1;
      @(negedge clock_100mhz);
      mode_toggle = 1'b0;
   endtask

   initial begin
      logic [11:0] v0, v1;
      int cnt, cd_cycles, run_start, first_pulse;
      bit found;
      reset = 1'b1;
      mode_toggle = 0; manual_step = 0; hard_breakpoint = 0;
      soft_breakpoint = 0; countdown_enable = 0;
      channel_active  = 2'b11;
      channel_divisor = {5'd3, 5'd0};
      repeat (3) @(negedge clock_100mhz);
      check("reset_mode", mode, 2'd0);
      check("reset_enable", clock_enable, 2'b00);
      check("reset_cd_active", countdown_active, 1'b0);
      reset = 1'b0;

      // Divisors {0,3}: ch0 every cycle; ch1 has its reset-divisor pulse, then every 4th.
      for (int i = 0; i < 12; i++) begin
         @(negedge clock_100mhz);
         v0[i] = clock_enable[0];
         v1[i] = clock_enable[1];
      end
      check("ch0_continuous", v0, 12'hFFF);
      check("ch1_div3_pattern", v1, 12'h111);

      pulse_toggle();
      check("manual_mode", mode, 2'd1);
      cnt = 0;
      for (int j = 0; j < 3; j++) begin
         manual_step = 1'b1;
         @(negedge clock_100mhz);
         manual_step = 1'b0;
         check("step_pulse", clock_enable, 2'b11);
         cnt += int'(clock_enable != 0);
         for (int i = 0; i < 4; i++) begin
            @(negedge clock_100mhz);
            cnt += int'(clock_enable != 0);
         end
      end
      check("step_pulse_count", cnt, 3);

      pulse_toggle();
      check("back_to_run", mode, 2'd0);

      countdown_enable = 1'b1;
      soft_breakpoint  = 1'b1;
      cd_cycles = 0; run_start = -1; first_pulse = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock_100mhz);
         if (mode == 2'd3) cd_cycles++;
         else if (cd_cycles > 0) begin
            if (run_start < 0) run_start = i;
            if (first_pulse < 0 && clock_enable[1]) first_pulse = i;
         end
      end
      check("countdown_cycles", cd_cycles, CDN);
      check("reentry_first_pulse", first_pulse - run_start + 1, 5);

      soft_breakpoint = 1'b0;
      repeat (2) @(negedge clock_100mhz);
      hard_breakpoint = 1'b1; soft_breakpoint = 1'b1;
      pulse_toggle();
      check("hard_wins", mode, 2'd2);
      pulse_toggle();
      check("halt_toggle_blocked", mode, 2'd2);
      hard_breakpoint = 1'b0;
      @(negedge clock_100mhz);
      manual_step = 1'b1;
      @(negedge clock_100mhz);
      manual_step = 1'b0;
      check("halt_step", clock_enable, 2'b11);
      check("halt_step_mode", mode, 2'd2);
      @(negedge clock_100mhz);
      check("halt_step_single", clock_enable, 2'b00);
      pulse_toggle();
      check("halt_resume", mode, 2'd0);

      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock_100mhz);
         if (clock_enable[1]) found = 1'b1;
      end
      check("ch1_pulse_seen", found, 1'b1);
      channel_divisor[2*DW-1:DW] = 5'd1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock_100mhz);
         v1[i] = clock_enable[1];
      end
      check("ch1_div_change", v1[7:0], 8'hA8);

      soft_breakpoint = 1'b0;
      @(negedge clock_100mhz);
      soft_breakpoint = 1'b1;
      @(negedge clock_100mhz);
      check("cd_entry", mode, 2'd3);
      repeat (2) @(negedge clock_100mhz);
      countdown_enable = 1'b0;
      @(negedge clock_100mhz);
      check("cd_abort_halt", mode, 2'd2);
      countdown_enable = 1'b1;
      pulse_toggle();
      check("abort_resume", mode, 2'd0);

      soft_breakpoint = 1'b0;
      @(negedge clock_100mhz);
      soft_breakpoint = 1'b1;
      repeat (4) @(negedge clock_100mhz);
      check("cd_before_reset", mode, 2'd3);
      @(posedge clock_100mhz);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_mode", mode, 2'd0);
      check("async_reset_enable", clock_enable, 2'b00);
      check("async_reset_cd_active", countdown_active, 1'b0);
      soft_breakpoint  = 1'b0;
      countdown_enable = 1'b0;
      repeat (2) @(negedge clock_100mhz);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock_100mhz);
         v0[i] = clock_enable[0];
         v1[i] = clock_enable[1];
      end
      check("post_reset_ch0", v0[5:0], 6'h3F);
      check("post_reset_ch1", v1[5:0], 6'h15);

      channel_active = 2'b01;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock_100mhz);
         cnt += int'(clock_enable[1]);
      end
      check("inactive_ch1_quiet", cnt, 0);
      channel_active = 2'b11;
      repeat (8) @(negedge clock_100mhz);

      @(posedge clock_100mhz);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
